// File: rtl/button_io.sv
// button_io: memory-mapped push-button input peripheral.
//
// Each button is brought through a two-flop synchronizer and a debounce
// counter. Debounced transitions set sticky PRESS/RELEASE flags and bump a
// saturating press counter. The core reads four words:
//   0 STATE   (RO)   debounced levels
//   1 PRESS   (W1C)  sticky rising-edge flags
//   2 RELEASE (W1C)  sticky falling-edge flags
//   3 COUNT   (W=clr) 16-bit saturating press count
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous active-high reset
//   btn_raw    asynchronous button levels, 1 = pressed
//   sel        bus address falls inside this block's window
//   mem_write  store strobe
//   mem_addr   word offset within the window
//   mem_wdata  store data
//   mem_rdata  combinational read data for mem_addr
//   irq        registered, high while any PRESS or RELEASE flag is set
module button_io #(
    parameter int unsigned NBTN     = 3,
    parameter int unsigned DEBOUNCE = 200000,
    parameter int unsigned CNT_W    = 18
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NBTN-1:0] btn_raw,
    input  logic            sel,
    input  logic            mem_write,
    input  logic [1:0]      mem_addr,
    input  logic [31:0]     mem_wdata,
    output logic [31:0]     mem_rdata,
    output logic            irq
);

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE - 1);

    logic [NBTN-1:0]  s1_q, s2_q;
    logic [NBTN-1:0]  stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q [NBTN];
    logic [CNT_W-1:0] cnt_d [NBTN];
    logic [NBTN-1:0]  rise, fall;

    logic [NBTN-1:0]  press_q, press_d;
    logic [NBTN-1:0]  release_q, release_d;
    logic [15:0]      count_q, count_d;
    logic             irq_q, irq_d;

    logic             wr_en;
    logic [NBTN-1:0]  clr_press, clr_release;
    logic             clr_count;
    logic [3:0]       n_rise;
    logic [16:0]      count_sum;

    // Only the low NBTN data bits carry W1C masks; the rest are don't-care.
    logic unused_wdata;
    assign unused_wdata = ^mem_wdata[31:NBTN];

    // Debounce: count consecutive cycles where the synchronized level
    // disagrees with the accepted level; any agreement restarts the count.
    always_comb begin
        stable_d = stable_q;
        rise     = '0;
        fall     = '0;
        for (int i = 0; i < int'(NBTN); i++) begin
            cnt_d[i] = cnt_q[i];
            if (s2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CntMax) begin
                stable_d[i] = s2_q[i];
                cnt_d[i]    = '0;
                rise[i]     = s2_q[i];
                fall[i]     = ~s2_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    assign wr_en       = sel & mem_write;
    assign clr_press   = (wr_en && mem_addr == 2'd1) ? mem_wdata[NBTN-1:0] : '0;
    assign clr_release = (wr_en && mem_addr == 2'd2) ? mem_wdata[NBTN-1:0] : '0;
    assign clr_count   = wr_en && mem_addr == 2'd3;

    // Set beats clear when both land on the same bit in one cycle.
    assign press_d   = (press_q & ~clr_press) | rise;
    assign release_d = (release_q & ~clr_release) | fall;

    always_comb begin
        n_rise = '0;
        for (int i = 0; i < int'(NBTN); i++) begin
            n_rise = n_rise + 4'(rise[i]);
        end
    end

    // A clearing write still absorbs this cycle's presses; the sum saturates.
    assign count_sum = {1'b0, (clr_count ? 16'h0000 : count_q)} + 17'(n_rise);
    assign count_d   = count_sum[16] ? 16'hFFFF : count_sum[15:0];

    // Derived from next-state flags so irq does not lag them by a cycle.
    assign irq_d = (|press_d) | (|release_d);

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q      <= '0;
            s2_q      <= '0;
            stable_q  <= '0;
            cnt_q     <= '{default: '0};
            press_q   <= '0;
            release_q <= '0;
            count_q   <= '0;
            irq_q     <= 1'b0;
        end else begin
            s1_q      <= btn_raw;
            s2_q      <= s1_q;
            stable_q  <= stable_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
            count_q   <= count_d;
            irq_q     <= irq_d;
        end
    end

    assign irq = irq_q;

    always_comb begin
        mem_rdata = '0;
        unique case (mem_addr)
            2'd0: mem_rdata[NBTN-1:0] = stable_q;
            2'd1: mem_rdata[NBTN-1:0] = press_q;
            2'd2: mem_rdata[NBTN-1:0] = release_q;
            2'd3: mem_rdata[15:0]     = count_q;
            default: mem_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_button_io.sv
module tb_button_io;

    localparam int NBTN = 3;
    localparam int DEB  = 4;

    logic            clk;
    logic            reset;
    logic [NBTN-1:0] btn_raw;
    logic            sel;
    logic            mem_write;
    logic [1:0]      mem_addr;
    logic [31:0]     mem_wdata;
    logic [31:0]     mem_rdata;
    logic            irq;

    button_io #(
        .NBTN    (NBTN),
        .DEBOUNCE(DEB),
        .CNT_W   (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_raw  (btn_raw),
        .sel      (sel),
        .mem_write(mem_write),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .irq      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: a level is accepted once the last DEB synchronized
    // samples all disagree with the currently accepted level.
    logic [NBTN-1:0] m_s1, m_s2, m_stable, m_press, m_rel;
    logic [DEB-1:0]  m_win [NBTN];
    int              m_count;
    logic            m_irq;

    logic [31:0] rd_state, rd_press, rd_rel, rd_count;
    logic        rd_irq;

    typedef struct {
        logic        rst;
        logic [2:0]  raw;
        logic [2:0]  e_state;
        logic [2:0]  e_press;
        logic [2:0]  e_rel;
        logic [15:0] e_count;
        logic        e_irq;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic [2:0] raw, logic [2:0] st, logic [2:0] pr,
                                logic [2:0] rl, logic [15:0] ct, logic iq);
        vec_t v;
        v.rst = r; v.raw = raw; v.e_state = st; v.e_press = pr;
        v.e_rel = rl; v.e_count = ct; v.e_irq = iq;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic [2:0] raw, input logic w,
                              input logic [1:0] a, input logic [31:0] d);
        logic [NBTN-1:0] rs, fl;
        int base;
        if (r) begin
            m_s1 = '0; m_s2 = '0; m_stable = '0; m_press = '0; m_rel = '0;
            m_count = 0; m_irq = 1'b0;
            for (int i = 0; i < NBTN; i++) m_win[i] = '0;
        end else begin
            rs = '0;
            fl = '0;
            for (int i = 0; i < NBTN; i++) begin
                m_win[i] = {m_win[i][DEB-2:0], m_s2[i]};
                if (m_win[i] == {DEB{~m_stable[i]}}) begin
                    if (m_stable[i]) fl[i] = 1'b1;
                    else             rs[i] = 1'b1;
                    m_stable[i] = ~m_stable[i];
                end
            end
            m_s2 = m_s1;
            m_s1 = raw;
            m_press = (m_press & ~((w && a == 2'd1) ? d[2:0] : 3'b000)) | rs;
            m_rel   = (m_rel   & ~((w && a == 2'd2) ? d[2:0] : 3'b000)) | fl;
            base = (w && a == 2'd3) ? 0 : m_count;
            base += $countones(rs);
            if (base > 65535) base = 65535;
            m_count = base;
            m_irq = (m_press != 0) || (m_rel != 0);
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, then read all
    // four words plus irq on the low phase and compare against the model.
    task automatic step(input logic r, input logic [2:0] raw, input logic w,
                        input logic [1:0] a, input logic [31:0] d);
        reset = r; btn_raw = raw; sel = w; mem_write = w; mem_addr = a; mem_wdata = d;
        @(posedge clk);
        model_edge(r, raw, w, a, d);
        @(negedge clk);
        sel = 1'b0; mem_write = 1'b0;
        mem_addr = 2'd0; #1 rd_state = mem_rdata;
        mem_addr = 2'd1; #1 rd_press = mem_rdata;
        mem_addr = 2'd2; #1 rd_rel   = mem_rdata;
        mem_addr = 2'd3; #1 rd_count = mem_rdata;
        rd_irq = irq;
        chk("mdl_state", rd_state, 32'(m_stable));
        chk("mdl_press", rd_press, 32'(m_press));
        chk("mdl_rel",   rd_rel,   32'(m_rel));
        chk("mdl_count", rd_count, 32'(m_count));
        chk("mdl_irq",   32'(rd_irq), 32'(m_irq));
    endtask

    task automatic hold(input logic [2:0] raw, input int n);
        for (int k = 0; k < n; k++) step(1'b0, raw, 1'b0, 2'd0, 32'd0);
    endtask

    logic [2:0] bpat [14];
    logic [2:0] rraw;

    initial begin
        // Directed vectors: hold-from-reset latency, then a short bounce.
        for (int k = 0; k < 2; k++) tbl.push_back(mk(1, 3'b000, 0, 0, 0, 0, 0));
        for (int k = 0; k < 8; k++)
            tbl.push_back(k < 5 ? mk(0, 3'b001, 0, 0, 0, 0, 0) : mk(0, 3'b001, 1, 1, 0, 1, 1));
        for (int k = 0; k < 2; k++) tbl.push_back(mk(1, 3'b000, 0, 0, 0, 0, 0));
        bpat = '{3'b010, 3'b010, 3'b010, 3'b000, 3'b010, 3'b010, 3'b010,
                 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
        for (int k = 0; k < 14; k++) tbl.push_back(mk(0, bpat[k], 0, 0, 0, 0, 0));

        for (int k = 0; k < tbl.size(); k++) begin
            step(tbl[k].rst, tbl[k].raw, 1'b0, 2'd0, 32'd0);
            chk($sformatf("tbl[%0d].state", k), rd_state, 32'(tbl[k].e_state));
            chk($sformatf("tbl[%0d].press", k), rd_press, 32'(tbl[k].e_press));
            chk($sformatf("tbl[%0d].rel", k),   rd_rel,   32'(tbl[k].e_rel));
            chk($sformatf("tbl[%0d].count", k), rd_count, 32'(tbl[k].e_count));
            chk($sformatf("tbl[%0d].irq", k),   32'(rd_irq), 32'(tbl[k].e_irq));
        end

        // Press/release of button 2, then W1C of each flag.
        step(1'b1, 3'b000, 1'b0, 2'd0, 32'd0);
        step(1'b1, 3'b000, 1'b0, 2'd0, 32'd0);
        hold(3'b100, 20);
        hold(3'b000, 12);
        chk("s3_press", rd_press, 32'h4);
        chk("s3_rel",   rd_rel,   32'h4);
        chk("s3_irq",   32'(rd_irq), 32'h1);
        step(1'b0, 3'b000, 1'b1, 2'd1, 32'h4);
        chk("s3_press_clr", rd_press, 32'h0);
        chk("s3_rel_kept",  rd_rel,   32'h4);
        chk("s3_irq_kept",  32'(rd_irq), 32'h1);
        step(1'b0, 3'b000, 1'b1, 2'd2, 32'h4);
        chk("s3_rel_clr", rd_rel, 32'h0);
        chk("s3_irq_low", 32'(rd_irq), 32'h0);

        // W1C of PRESS[0] on the same edge as a new rise[0].
        hold(3'b001, 10);
        hold(3'b000, 10);
        chk("s4_press_pre", rd_press, 32'h1);
        hold(3'b001, 5);
        chk("s4_state_pre", rd_state, 32'h0);
        step(1'b0, 3'b001, 1'b1, 2'd1, 32'h1);
        chk("s4_state", rd_state, 32'h1);
        chk("s4_press", rd_press, 32'h1);
        chk("s4_count", rd_count, 32'd3);

        // COUNT write coinciding with two simultaneous accepted presses.
        hold(3'b000, 10);
        hold(3'b101, 5);
        step(1'b0, 3'b101, 1'b1, 2'd3, 32'hDEAD);
        chk("s5_count", rd_count, 32'd2);
        chk("s5_press", rd_press, 32'h5);
        hold(3'b101, 3);
        hold(3'b000, 10);

        // Saturation: preload COUNT at its maximum, then press once more.
        m_count = 65535;
        force dut.count_q = 16'hFFFF;
        step(1'b0, 3'b000, 1'b0, 2'd0, 32'd0);
        release dut.count_q;
        hold(3'b010, 10);
        chk("s5_sat", rd_count, 32'hFFFF);
        chk("s5_sat_state", rd_state, 32'h2);
        hold(3'b000, 10);

        // Reset in the middle of a debounce with the button still held.
        hold(3'b001, 3);
        for (int k = 0; k < 2; k++) begin
            step(1'b1, 3'b001, 1'b0, 2'd0, 32'd0);
            chk("s6_rst_state", rd_state, 32'h0);
            chk("s6_rst_press", rd_press, 32'h0);
            chk("s6_rst_rel",   rd_rel,   32'h0);
            chk("s6_rst_count", rd_count, 32'h0);
            chk("s6_rst_irq",   32'(rd_irq), 32'h0);
        end
        for (int k = 0; k < 6; k++) begin
            step(1'b0, 3'b001, 1'b0, 2'd0, 32'd0);
            chk($sformatf("s6_press_e%0d", k), rd_press, (k < 5) ? 32'h0 : 32'h1);
        end
        chk("s6_count", rd_count, 32'd1);

        // Random buttons, bus writes and occasional resets against the model.
        rraw = 3'b000;
        for (int n = 0; n < 1500; n++) begin
            logic       w;
            logic [1:0] a;
            for (int i = 0; i < NBTN; i++)
                if ($urandom_range(0, 5) == 0) rraw[i] = ~rraw[i];
            w = ($urandom_range(0, 3) == 0);
            a = 2'($urandom_range(0, 3));
            step(($urandom_range(0, 199) == 0), rraw, w, a, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/button_io.md
# button_io

Memory-mapped input peripheral for the pipelined RISC-V SoC: the read-side counterpart of the LED output register. It synchronizes and debounces the board push-buttons, keeps sticky press/release event flags and a press counter, and exposes them to the core as four 32-bit words on the data-memory bus inside the IO region. The top level decodes the IO address and muxes `mem_rdata` between RAM, the LED register and this block.

## Interface
- `NBTN`, 3: number of buttons, 1..8.
- `DEBOUNCE`, 200000: consecutive stable cycles required to accept a level change, ≥2. This is about 16 ms at 12 MHz. Benches override it to 4.
- `CNT_W`, 18: debounce counter width. Must satisfy 2^CNT_W > DEBOUNCE.

- `clk`  in  1  system clock; every register updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `btn_raw`  in  NBTN  asynchronous button levels, 1 = pressed. The top level inverts active-low pins.
- `sel`  in  1  high when the bus address falls in this block's IO window.
- `mem_write`  in  1  core store strobe.
- `mem_addr`  in  2  word offset, taken from core `mem_addr[3:2]`.
- `mem_wdata`  in  32  store data.
- `mem_rdata`  out  32  combinational read data for `mem_addr`, driven regardless of `sel`.
- `irq`  out  1  registered; high while any PRESS or RELEASE bit is set.

## Operation
- Register map (word offsets):
  - 0 STATE, read-only: `[NBTN-1:0]` holds the debounced levels. Writes are ignored.
  - 1 PRESS, write-1-to-clear: sticky 0→1 debounced-transition flags.
  - 2 RELEASE, write-1-to-clear: sticky 1→0 debounced-transition flags.
  - 3 COUNT: `[15:0]` is the total accepted press count. Any write clears it.
  - Unused bits always read 0.
- A write takes effect only when `sel & mem_write`. Reads have no side effects.
- Per-button pipeline:
  - Two-flop synchronizer `s1`→`s2`, then a debounce counter and a `stable` flop.
  - If `s2 == stable`: counter ← 0.
  - Otherwise, if counter == DEBOUNCE-1: `stable` ← `s2`, counter ← 0, and a one-cycle `rise` or `fall` pulse fires.
  - Otherwise: counter ← counter+1.
- Event latching:
  - PRESS[i] is set by `rise[i]`. RELEASE[i] is set by `fall[i]`.
  - A W1C write clears the bits written as 1.
  - If a set and a clear hit the same bit in the same cycle, the set wins.
- COUNT:
  - Each cycle, COUNT ← COUNT + popcount(rise), saturating at 16'hFFFF with no wrap.
  - On a COUNT write in the same cycle: COUNT ← popcount(rise). Increments are never lost.
- `irq` ← |PRESS_next | |RELEASE_next, registered, so it tracks the flags with no extra cycle of lag.
- Reset values: `s1`, `s2`, `stable`, counters, PRESS, RELEASE, COUNT and `irq` are all 0.
  - A button held through reset is therefore reported as a press DEBOUNCE+1 edges after reset deasserts.
- Reset mid-debounce discards the partial count. No event is generated for the interrupted transition.

## Timing
- Latency: `btn_raw` sampled into `s1` at edge N → STATE, PRESS/RELEASE, COUNT update at edge N+DEBOUNCE+1. `irq` rises at that same edge.
- Glitch rejection: any excursion of `s2` shorter than DEBOUNCE cycles produces no STATE change and no event.
- An excursion of exactly DEBOUNCE cycles is accepted.
- The counter restarts from 0 whenever `s2` returns to `stable`; mismatch cycles are not accumulated across bounces.
- A W1C or COUNT write at edge M is visible on `mem_rdata` in the cycle after M. `irq` falls at edge M if no flag remains set.
- `mem_rdata` is combinational from `mem_addr` and registers, so it is valid in the same cycle as the load address.
- Buttons are independent. Simultaneous accepted presses on k buttons set k PRESS bits and add k to COUNT in one cycle.

## Test plan
All scenarios use `DEBOUNCE`=4 and `NBTN`=3.
1. Reset, then hold `btn_raw`=3'b001 steady from edge 0. Required: STATE=1, PRESS=1, COUNT=1 and `irq`=1 at edge 5; all are 0 before edge 5.
2. Bounce: `btn_raw[1]` toggles high for 3 cycles, low for 1, high for 3, low. Required: STATE, PRESS and COUNT stay 0, and `irq` stays 0 throughout.
3. Press, then release button 2 after 20 cycles. Required: PRESS=3'b100 and RELEASE=3'b100. Write 3'b100 to PRESS, then read: PRESS=0, RELEASE=3'b100, `irq`=1. Write 3'b100 to RELEASE: `irq` falls at that write edge.
4. Collision: a W1C to PRESS bit 0 lands on the same edge as a new `rise[0]`. Required: PRESS[0] reads 1 afterwards.
5. Write COUNT in the same cycle as a simultaneous accepted press on buttons 0 and 2. Required: COUNT reads 2. Preload COUNT=16'hFFFF, then press once: COUNT stays 16'hFFFF.
6. Assert `reset` 2 cycles into a debounce of button 0, then release `reset` while the button is still held. Required: all reads return 0 during reset; PRESS[0] sets exactly DEBOUNCE+1 edges after reset deasserts; COUNT=1.
